// File: rtl/vote_button_if.sv
// Ballot-unit side of the vote controller: raw buttons and enable in, vote/conflict/busy out.
// The ballot unit is the master; vote_button_ctrl is the slave.
interface vote_button_if #(
    parameter int NUM_CH = 4
);
    localparam int ID_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] button;
    logic              vote_enable;
    logic              valid_vote;
    logic [ID_W-1:0]   vote_id;
    logic              conflict;
    logic              busy;

    modport master (
        output button, vote_enable,
        input  valid_vote, vote_id, conflict, busy
    );

    modport slave (
        input  button, vote_enable,
        output valid_vote, vote_id, conflict, busy
    );
endinterface

// File: rtl/vote_button_ctrl.sv
// Multi-channel vote validator: accepts a vote when exactly one synchronised button is held
// for HOLD_CYCLES cycles, then locks out until every button is released.
module vote_button_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 125000000,
    parameter int CNT_W       = 31
) (
    input  logic          clock,
    input  logic          reset,
    vote_button_if.slave  bus
);
    localparam int ID_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_e;

    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;

    // Two-flop synchroniser; everything downstream sees only sync2_q.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.button;
            sync2_q <= sync1_q;
        end
    end

    logic              s_none;
    logic              s_multi;
    logic [ID_W-1:0]   s_idx;
    logic [NUM_CH-1:0] ch_mask;

    state_e            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [ID_W-1:0]   ch_q,       ch_d;
    logic              valid_q,    valid_d;
    logic              conflict_q, conflict_d;
    logic [ID_W-1:0]   vote_id_q,  vote_id_d;
    logic              busy_q;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        s_none  = (sync2_q == '0);
        s_multi = ((sync2_q & (sync2_q - NUM_CH'(1))) != '0);
        s_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sync2_q[i]) begin
                s_idx = ID_W'(i);
            end
        end
        ch_mask = NUM_CH'(1) << ch_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        valid_d    = 1'b0;
        conflict_d = 1'b0;
        vote_id_d  = vote_id_q;

        case (state_q)
            IDLE: begin
                if (s_multi) begin
                    state_d    = WAIT_REL;
                    conflict_d = 1'b1;
                end else if (!s_none) begin
                    if (bus.vote_enable) begin
                        state_d = HOLD;
                        ch_d    = s_idx;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = WAIT_REL;
                    end
                end
            end

            HOLD: begin
                if (s_multi) begin
                    state_d    = WAIT_REL;
                    conflict_d = 1'b1;
                    cnt_d      = '0;
                end else if (sync2_q != ch_mask) begin
                    // Covers both release and a hop to another single button.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!bus.vote_enable) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d   = WAIT_REL;
                    valid_d   = 1'b1;
                    vote_id_d = ch_q;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WAIT_REL: begin
                if (s_none) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ch_q       <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
            vote_id_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
            vote_id_q  <= vote_id_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign bus.valid_vote = valid_q;
    assign bus.vote_id    = vote_id_q;
    assign bus.conflict   = conflict_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_vote_button_ctrl.sv
// Bench for vote_button_ctrl: directed scenarios plus random button traffic, all checked
// cycle by cycle against a press-streak model of the voting rules.
module tb_vote_button_ctrl;
    localparam int NUM_CH = 4;
    localparam int HOLD   = 4;
    localparam int CNT_W  = 3;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    vote_button_if #(.NUM_CH(NUM_CH)) bus ();

    vote_button_ctrl #(
        .NUM_CH      (NUM_CH),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int votes     = 0;
    int conflicts = 0;
    int last_id   = 0;
    int last_vote_cyc = 0;

    // Model: a vote needs HOLD consecutive enabled samples of the same single button;
    // after a vote, conflict or disabled press nothing counts until all buttons are up.
    logic [3:0] m_sync1, m_sync2;
    bit         locked;
    int         streak;
    int         chan;
    bit         exp_valid, exp_conflict, exp_busy;
    int         exp_id;

    task automatic model_clear();
        m_sync1 = '0; m_sync2 = '0;
        locked = 0; streak = 0; chan = 0;
        exp_valid = 0; exp_conflict = 0; exp_busy = 0; exp_id = 0;
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic en, input logic rst);
        logic [3:0] s;
        if (rst) begin
            model_clear();
            return;
        end
        s = m_sync2;
        m_sync2 = m_sync1;
        m_sync1 = raw;
        exp_valid = 0;
        exp_conflict = 0;
        if (locked) begin
            if (s == 0) locked = 0;
        end else if ($countones(s) > 1) begin
            exp_conflict = 1;
            locked = 1;
            streak = 0;
        end else if (streak > 0) begin
            if (s != (4'b0001 << chan)) begin
                streak = 0;
            end else if (!en) begin
                locked = 1;
                streak = 0;
            end else begin
                streak++;
                if (streak == HOLD) begin
                    exp_valid = 1;
                    exp_id = chan;
                    locked = 1;
                    streak = 0;
                end
            end
        end else if (s != 0) begin
            if (en) begin
                streak = 1;
                for (int i = 0; i < NUM_CH; i++) if (s[i]) chan = i;
            end else begin
                locked = 1;
            end
        end
        exp_busy = locked || (streak > 0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [3:0] b;
        logic       e;
        logic       r;
        b = bus.button;
        e = bus.vote_enable;
        r = reset;
        @(posedge clock);
        model_edge(b, e, r);
        @(negedge clock);
        cyc++;
        check("valid_vote", 32'(bus.valid_vote), 32'(exp_valid));
        check("vote_id",    32'(bus.vote_id),    32'(exp_id));
        check("conflict",   32'(bus.conflict),   32'(exp_conflict));
        check("busy",       32'(bus.busy),       32'(exp_busy));
        if (bus.valid_vote === 1'b1) begin
            votes++;
            last_vote_cyc = cyc;
            last_id = int'(bus.vote_id);
        end
        if (bus.conflict === 1'b1) conflicts++;
    endtask

    task automatic press(input logic [3:0] b, input int n);
        bus.button = b;
        repeat (n) tick();
    endtask

    initial begin
        int v0, c0, start;
        logic [3:0] b;

        model_clear();
        reset = 1'b1;
        bus.button = '0;
        bus.vote_enable = 1'b0;
        repeat (2) tick();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_id",   32'(bus.vote_id), 32'd0);
        reset = 1'b0;
        bus.vote_enable = 1'b1;
        press(4'b0000, 3);

        // Long hold of button 2: exactly one vote, fixed latency, busy drops two edges after release.
        v0 = votes;
        start = cyc + 1;
        press(4'b0100, 20);
        check("s1_votes", 32'(votes - v0), 32'd1);
        check("s1_id", 32'(last_id), 32'd2);
        check("s1_latency", 32'(last_vote_cyc - start), 32'd5);
        press(4'b0000, 2);
        check("s1_busy_before_release_seen", 32'(bus.busy), 32'd1);
        press(4'b0000, 1);
        check("s1_busy_after_release_seen", 32'(bus.busy), 32'd0);
        press(4'b0000, 3);

        // Short press: no vote, no conflict.
        v0 = votes; c0 = conflicts;
        press(4'b0001, 3);
        press(4'b0000, 6);
        check("s2_votes", 32'(votes - v0), 32'd0);
        check("s2_conflicts", 32'(conflicts - c0), 32'd0);
        check("s2_idle", 32'(bus.busy), 32'd0);

        // Simultaneous press is a conflict; then a clean press of button 3.
        v0 = votes; c0 = conflicts;
        press(4'b0011, 6);
        check("s3_conflicts", 32'(conflicts - c0), 32'd1);
        check("s3_no_vote", 32'(votes - v0), 32'd0);
        press(4'b0000, 4);
        press(4'b1000, 4);
        press(4'b0000, 6);
        check("s3_votes", 32'(votes - v0), 32'd1);
        check("s3_id", 32'(last_id), 32'd3);

        // Channel hop restarts the count on the new channel.
        v0 = votes;
        press(4'b0010, 2);
        press(4'b0100, 12);
        check("s4_votes", 32'(votes - v0), 32'd1);
        check("s4_id", 32'(last_id), 32'd2);
        press(4'b0000, 5);

        // Disabled press locks out until release, even after enable rises.
        v0 = votes;
        bus.vote_enable = 1'b0;
        press(4'b0001, 5);
        bus.vote_enable = 1'b1;
        press(4'b0001, 10);
        check("s5_no_vote", 32'(votes - v0), 32'd0);
        check("s5_locked", 32'(bus.busy), 32'd1);
        press(4'b0000, 5);
        press(4'b0001, 8);
        check("s5_votes", 32'(votes - v0), 32'd1);
        check("s5_id", 32'(last_id), 32'd0);
        press(4'b0000, 5);

        // Reset mid-count aborts; the still-held button then counts afresh.
        v0 = votes;
        press(4'b0001, 4);
        reset = 1'b1;
        tick();
        check("s6_reset_valid", 32'(bus.valid_vote), 32'd0);
        check("s6_reset_busy", 32'(bus.busy), 32'd0);
        check("s6_reset_id", 32'(bus.vote_id), 32'd0);
        reset = 1'b0;
        start = cyc + 1;
        press(4'b0001, 10);
        check("s6_votes", 32'(votes - v0), 32'd1);
        check("s6_latency", 32'(last_vote_cyc - start), 32'd5);
        press(4'b0000, 5);

        // Random traffic against the model.
        for (int seg = 0; seg < 300; seg++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: b = 4'(1 << $urandom_range(0, 3));
                5, 6:          b = 4'b0000;
                7, 8:          b = 4'b0011 << $urandom_range(0, 2);
                default:       b = 4'($urandom_range(0, 15));
            endcase
            bus.vote_enable = ($urandom_range(0, 99) < 85);
            reset = ($urandom_range(0, 99) < 2);
            if (reset) begin
                bus.button = b;
                tick();
                reset = 1'b0;
            end
            press(b, $urandom_range(1, 8));
        end
        reset = 1'b0;
        press(4'b0000, 5);
        check("random_saw_votes", 32'(votes > 5), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
